// File: rtl/i2s_tx.sv
// I2S slave transmitter: follows the codec word clock and shifts one left/right
// sample pair per frame onto dacdat, MSB first, with the standard one-bit delay.
module i2s_tx #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  sck,
   input  logic                  rst_n,
   input  logic                  lrck,
   input  logic [DATA_WIDTH-1:0] ldata,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic                  data_vld,
   output logic                  data_rdy,
   output logic                  dacdat,
   output logic                  underrun,
   output logic                  frame_sync
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic                  lrck_d;
   logic                  synced;
   logic                  pend_full;
   logic [DATA_WIDTH-1:0] pend_l;
   logic [DATA_WIDTH-1:0] pend_r;
   logic [DATA_WIDTH-1:0] cur_l;
   logic [DATA_WIDTH-1:0] cur_r;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]      cnt;

   logic                  fall;
   logic                  rise;
   logic                  accept;
   logic                  slot_start;
   logic [DATA_WIDTH-1:0] load_l;
   logic [DATA_WIDTH-1:0] load_r;
   logic [DATA_WIDTH-1:0] slot_word;

   always_comb begin
      fall       = lrck_d & ~lrck;
      rise       = ~lrck_d & lrck;
      data_rdy   = ~pend_full;
      accept     = data_vld & ~pend_full;
      load_l     = cur_l;
      load_r     = cur_r;
      slot_word  = cur_r;
      // A right edge before the first left edge would start mid-frame, so it is skipped.
      slot_start = fall | (rise & synced);
      if (fall) begin
         load_l    = pend_full ? pend_l : '0;
         load_r    = pend_full ? pend_r : '0;
         slot_word = load_l;
      end
   end

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         lrck_d     <= 1'b0;
         synced     <= 1'b0;
         pend_full  <= 1'b0;
         pend_l     <= '0;
         pend_r     <= '0;
         cur_l      <= '0;
         cur_r      <= '0;
         shreg      <= '0;
         cnt        <= '0;
         dacdat     <= 1'b0;
         underrun   <= 1'b0;
         frame_sync <= 1'b0;
      end else begin
         lrck_d     <= lrck;
         underrun   <= fall & ~pend_full;
         frame_sync <= fall;

         if (fall) begin
            synced <= 1'b1;
            cur_l  <= load_l;
            cur_r  <= load_r;
         end

         // Accept needs an empty buffer and a left edge only empties it, so the
         // two never fight; an accept during an underrun edge stays pending.
         if (accept) begin
            pend_l    <= ldata;
            pend_r    <= rdata;
            pend_full <= 1'b1;
         end else if (fall) begin
            pend_full <= 1'b0;
         end

         // Slot edges win over an unfinished word, truncating its LSBs.
         if (slot_start) begin
            dacdat <= slot_word[DATA_WIDTH-1];
            shreg  <= slot_word << 1;
            cnt    <= CNT_LOAD;
         end else if (cnt != '0) begin
            dacdat <= shreg[DATA_WIDTH-1];
            shreg  <= shreg << 1;
            cnt    <= cnt - CNT_ONE;
         end else begin
            dacdat <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a vector table for the basic frames and underruns,
// then hand-written sequences for handshake stall, short slots and mid-word reset.
module tb_i2s_tx;

   logic       sck;
   logic       rst_n;
   logic       lrck;
   logic [7:0] ldata;
   logic [7:0] rdata;
   logic       data_vld;
   logic       data_rdy;
   logic       dacdat;
   logic       underrun;
   logic       frame_sync;

   int checks = 0;
   int errors = 0;

   i2s_tx #(.DATA_WIDTH(8)) dut (
      .sck        (sck),
      .rst_n      (rst_n),
      .lrck       (lrck),
      .ldata      (ldata),
      .rdata      (rdata),
      .data_vld   (data_vld),
      .data_rdy   (data_rdy),
      .dacdat     (dacdat),
      .underrun   (underrun),
      .frame_sync (frame_sync)
   );

   initial sck = 1'b0;
   always #5 sck = ~sck;

   typedef struct {
      logic       lr;
      logic       vld;
      logic [7:0] l;
      logic [7:0] r;
      logic       dac;
      logic       rdy;
      logic       ur;
      logic       fs;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // lrck moves on the falling edge; outputs are sampled 1 unit after the rising edge.
   task automatic step(input logic lr);
      @(negedge sck);
      lrck = lr;
      @(posedge sck);
      #1;
   endtask

   task automatic add_vec(input logic lr, input logic vld, input logic [7:0] l, input logic [7:0] r,
                          input logic dac, input logic rdy, input logic ur, input logic fs);
      vec_t v;
      v.lr = lr; v.vld = vld; v.l = l; v.r = r;
      v.dac = dac; v.rdy = rdy; v.ur = ur; v.fs = fs;
      vecs.push_back(v);
   endtask

   task automatic add_slot(input logic lr, input int len, input logic [15:0] bits,
                           input logic ur0, input logic fs0, input logic rdy);
      for (int i = 0; i < len; i++)
         add_vec(lr, 1'b0, 8'h00, 8'h00, bits[15-i], rdy, (i == 0) ? ur0 : 1'b0, (i == 0) ? fs0 : 1'b0);
   endtask

   task automatic run_slot(input logic lr, input int start, input int len, input logic [15:0] bits,
                           input logic ur0, input logic fs0, input logic rdy);
      for (int i = start; i < start + len; i++) begin
         step(lr);
         check($sformatf("slot_dac[%0d]", i), 32'(dacdat), 32'(bits[15-i]));
         check("slot_rdy", 32'(data_rdy), 32'(rdy));
         check("slot_underrun", 32'(underrun), 32'((i == 0) ? ur0 : 1'b0));
         check("slot_fsync", 32'(frame_sync), 32'((i == 0) ? fs0 : 1'b0));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      lrck     = 1'b0;
      ldata    = 8'h00;
      rdata    = 8'h00;
      data_vld = 1'b0;

      // Right edge first with a pair pending (must stay silent), then the A5/3C frame,
      // then three frames with nothing offered.
      add_vec(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      add_slot(1'b1, 15, 16'h0000, 1'b0, 1'b0, 1'b0);
      add_slot(1'b0, 16, 16'b1010_0101_0000_0000, 1'b0, 1'b1, 1'b1);
      add_slot(1'b1, 16, 16'b0011_1100_0000_0000, 1'b0, 1'b0, 1'b1);
      for (int f = 0; f < 3; f++) begin
         add_slot(1'b0, 16, 16'h0000, 1'b1, 1'b1, 1'b1);
         add_slot(1'b1, 16, 16'h0000, 1'b0, 1'b0, 1'b1);
      end

      #22;
      check("rst_dacdat", 32'(dacdat), 32'd0);
      check("rst_rdy", 32'(data_rdy), 32'd1);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_fsync", 32'(frame_sync), 32'd0);
      @(negedge sck);
      rst_n = 1'b1;

      foreach (vecs[k]) begin
         data_vld = vecs[k].vld;
         ldata    = vecs[k].l;
         rdata    = vecs[k].r;
         step(vecs[k].lr);
         check($sformatf("vec%0d_dac", k), 32'(dacdat), 32'(vecs[k].dac));
         check($sformatf("vec%0d_rdy", k), 32'(data_rdy), 32'(vecs[k].rdy));
         check($sformatf("vec%0d_underrun", k), 32'(underrun), 32'(vecs[k].ur));
         check($sformatf("vec%0d_fsync", k), 32'(frame_sync), 32'(vecs[k].fs));
      end
      data_vld = 1'b0;

      // Held data_vld: 11/22 taken at once, 33/44 waits for the left edge to free the buffer.
      data_vld = 1'b1; ldata = 8'h11; rdata = 8'h22;
      step(1'b1);
      check("hold_first_accept_rdy", 32'(data_rdy), 32'd0);
      ldata = 8'h33; rdata = 8'h44;
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("hold_stall_rdy", 32'(data_rdy), 32'd0);
      end
      step(1'b0);
      check("hold_fall_dac", 32'(dacdat), 32'd0);
      check("hold_fall_fsync", 32'(frame_sync), 32'd1);
      check("hold_fall_underrun", 32'(underrun), 32'd0);
      check("hold_fall_rdy", 32'(data_rdy), 32'd1);
      step(1'b0);
      check("hold_second_accept_rdy", 32'(data_rdy), 32'd0);
      check("hold_bit1_dac", 32'(dacdat), 32'd0);
      data_vld = 1'b0;
      run_slot(1'b0, 2, 14, 16'h1100, 1'b0, 1'b0, 1'b0);
      run_slot(1'b1, 0, 16, 16'h2200, 1'b0, 1'b0, 1'b0);
      run_slot(1'b0, 0, 16, 16'h3300, 1'b0, 1'b1, 1'b1);
      run_slot(1'b1, 0, 16, 16'h4400, 1'b0, 1'b0, 1'b1);

      // Four-bit slots truncate each word; the following slot must restart at its MSB.
      data_vld = 1'b1; ldata = 8'hF0; rdata = 8'h0F;
      step(1'b1);
      check("short_push_rdy", 32'(data_rdy), 32'd0);
      data_vld = 1'b0;
      run_slot(1'b0, 0, 4, 16'hF000, 1'b0, 1'b1, 1'b1);
      data_vld = 1'b1; ldata = 8'h9C; rdata = 8'hC3;
      run_slot(1'b1, 0, 4, 16'h0F00, 1'b0, 1'b0, 1'b0);
      data_vld = 1'b0;
      run_slot(1'b0, 0, 4, 16'h9C00, 1'b0, 1'b1, 1'b1);
      run_slot(1'b1, 0, 4, 16'hC300, 1'b0, 1'b0, 1'b1);

      // Reset three bits into A5 with a second pair pending; that pair must be lost.
      data_vld = 1'b1; ldata = 8'hA5; rdata = 8'h3C;
      step(1'b1);
      data_vld = 1'b0;
      run_slot(1'b0, 0, 2, 16'hA500, 1'b0, 1'b1, 1'b1);
      data_vld = 1'b1; ldata = 8'h5A; rdata = 8'h5A;
      step(1'b0);
      data_vld = 1'b0;
      check("prerst_dac", 32'(dacdat), 32'd1);
      check("prerst_rdy", 32'(data_rdy), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_dac", 32'(dacdat), 32'd0);
      check("async_rst_rdy", 32'(data_rdy), 32'd1);
      @(negedge sck);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         check("postrst_left_dac", 32'(dacdat), 32'd0);
         check("postrst_left_fsync", 32'(frame_sync), 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1);
         check("postrst_right_dac", 32'(dacdat), 32'd0);
         check("postrst_right_fsync", 32'(frame_sync), 32'd0);
      end
      step(1'b0);
      check("postrst_fall_underrun", 32'(underrun), 32'd1);
      check("postrst_fall_fsync", 32'(frame_sync), 32'd1);
      check("postrst_fall_dac", 32'(dacdat), 32'd0);
      step(1'b0);
      check("postrst_after_underrun", 32'(underrun), 32'd0);
      check("postrst_after_dac", 32'(dacdat), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
